// File: rtl/ls74_pkg.sv
// Shared types and constants for the 74-series shift-register models.
package ls74_pkg;

  localparam int LS165_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } seq_state_t;

endpackage

// File: rtl/ls165_stage.sv
// One 74LS165 package: 8-bit register with load > hold > shift priority.
module ls165_stage
  import ls74_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ld_i,
  input  logic                  inh_i,
  input  logic                  ser_i,
  input  logic [LS165_BITS-1:0] d_i,
  output logic                  qh_o
);

  logic [LS165_BITS-1:0] sr_q;
  logic [LS165_BITS-1:0] sr_d;

  always_comb begin
    // NOTE: default first so every path assigns sr_d and no latch is inferred.
    sr_d = sr_q;
    if (ld_i) begin
      sr_d = d_i;
    end else if (!inh_i) begin
      sr_d = {sr_q[LS165_BITS-2:0], ser_i};
    end
  end

  // NOTE: reset is sampled on the clock edge, so it lives inside the clocked
  // branch rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: non-blocking so every register samples pre-edge values.
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign qh_o = sr_q[LS165_BITS-1];

endmodule

// File: rtl/ls165_piso_serializer.sv
// Cascaded 74LS165 chain plus a frame sequencer that loads d and emits it MSB-first.
module ls165_piso_serializer
  import ls74_pkg::*;
#(
  parameter int N_CHIPS = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sh_ld_n,
  input  logic                          clk_inh,
  input  logic                          ser,
  input  logic [LS165_BITS*N_CHIPS-1:0] d,
  input  logic                          start,
  output logic                          q_h,
  output logic                          q_h_n,
  output logic                          bit_vld,
  output logic                          busy,
  output logic                          done
);

  localparam int WIDTH = LS165_BITS * N_CHIPS;
  localparam int CNT_W = $clog2(WIDTH);

  seq_state_t       state_q;
  seq_state_t       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             ld;
  logic             inh;

  // chain[k] is QH of chip k; chain[N_CHIPS] is the external serial input.
  logic [N_CHIPS:0] chain;

  assign chain[N_CHIPS] = ser;

  // Chip 0 holds the most significant byte, so its QH is the frame output.
  for (genvar k = 0; k < N_CHIPS; k++) begin : g_chip
    ls165_stage u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .ld_i  (ld),
      .inh_i (inh),
      .ser_i (chain[k+1]),
      .d_i   (d[WIDTH-1-LS165_BITS*k -: LS165_BITS]),
      .qh_o  (chain[k])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          cnt_d   = CNT_W'(WIDTH - 1);
        end
      end
      SHIFT: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Register controls are shared by all chips; manual pins only matter in IDLE.
  always_comb begin
    ld      = 1'b0;
    inh     = 1'b1;
    bit_vld = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          ld = 1'b1;
        end else begin
          ld  = ~sh_ld_n;
          inh = clk_inh;
        end
      end
      SHIFT: begin
        bit_vld = 1'b1;
        inh     = (cnt_q == '0);
      end
      DONE:    done = 1'b1;
      default: inh  = 1'b1;
    endcase
  end

  assign q_h   = chain[0];
  assign q_h_n = ~chain[0];

endmodule

// File: tb/tb_ls165_piso_serializer.sv
// Directed bench for the '165 serializer: one 8-bit and one 16-bit instance.
module tb_ls165_piso_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sh_ld_n;
  logic        clk_inh;
  logic        ser;
  logic        start;
  logic [7:0]  d8;
  logic [15:0] d16;

  logic q_h8, q_h_n8, bit_vld8, busy8, done8;
  logic q_h16, q_h_n16, bit_vld16, busy16, done16;
  logic [4:0] o8, o16;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ls165_piso_serializer #(.N_CHIPS(1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .sh_ld_n(sh_ld_n), .clk_inh(clk_inh), .ser(ser),
    .d(d8), .start(start), .q_h(q_h8), .q_h_n(q_h_n8), .bit_vld(bit_vld8),
    .busy(busy8), .done(done8)
  );

  ls165_piso_serializer #(.N_CHIPS(2)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .sh_ld_n(sh_ld_n), .clk_inh(clk_inh), .ser(ser),
    .d(d16), .start(start), .q_h(q_h16), .q_h_n(q_h_n16), .bit_vld(bit_vld16),
    .busy(busy16), .done(done16)
  );

  assign o8  = {q_h8, q_h_n8, bit_vld8, busy8, done8};
  assign o16 = {q_h16, q_h_n16, bit_vld16, busy16, done16};

  // Expected {q_h, q_h_n, bit_vld, busy, done}.
  function automatic logic [4:0] exp_o(input logic qh, input logic vld,
                                       input logic bsy, input logic dn);
    return {qh, ~qh, vld, bsy, dn};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; sh_ld_n = 1'b1; clk_inh = 1'b1; ser = 1'b0;
    d8 = 8'hFF; d16 = 16'hFFFF;
    step(); step();
    vectors++;
    if (o8 !== exp_o(1'b0, 1'b0, 1'b0, 1'b0)) begin
      miscompares++; $display("FAIL reset_w8: got %b want %b", o8, exp_o(0, 0, 0, 0));
    end
    vectors++;
    if (o16 !== exp_o(1'b0, 1'b0, 1'b0, 1'b0)) begin
      miscompares++; $display("FAIL reset_w16: got %b want %b", o16, exp_o(0, 0, 0, 0));
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_frame_a5();
    logic [7:0] pat = 8'hA5;
    d8 = pat; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (o8 !== exp_o(pat[7-i], 1'b1, 1'b1, 1'b0)) begin
        miscompares++;
        $display("FAIL a5_bit%0d: got %b want %b", i, o8, exp_o(pat[7-i], 1, 1, 0));
      end
      step();
    end
    vectors++;
    if (o8 !== exp_o(pat[0], 1'b0, 1'b1, 1'b1)) begin
      miscompares++; $display("FAIL a5_done: got %b want %b", o8, exp_o(pat[0], 0, 1, 1));
    end
    step();
    vectors++;
    if (o8 !== exp_o(pat[0], 1'b0, 1'b0, 1'b0)) begin
      miscompares++; $display("FAIL a5_idle: got %b want %b", o8, exp_o(pat[0], 0, 0, 0));
    end
  endtask

  task automatic test_wide();
    logic [15:0] pat16 = 16'h8001;
    int busy_cnt = 0;
    repeat (10) step();
    d16 = pat16; ser = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 25; c++) begin
      if (busy16) busy_cnt++;
      if (c < 16) begin
        vectors++;
        if (o16 !== exp_o(pat16[15-c], 1'b1, 1'b1, 1'b0)) begin
          miscompares++;
          $display("FAIL w16_bit%0d: got %b want %b", c, o16, exp_o(pat16[15-c], 1, 1, 0));
        end
      end else if (c == 16) begin
        vectors++;
        if (o16 !== exp_o(pat16[0], 1'b0, 1'b1, 1'b1)) begin
          miscompares++;
          $display("FAIL w16_done: got %b want %b", o16, exp_o(pat16[0], 0, 1, 1));
        end
      end
      step();
    end
    vectors++;
    if (busy_cnt !== 17) begin
      miscompares++; $display("FAIL w16_busy_cycles: got %0d want 17", busy_cnt);
    end
  endtask

  task automatic test_manual();
    logic [7:0] pat = 8'b1110_0001;
    d8 = 8'hF0; sh_ld_n = 1'b0; clk_inh = 1'b1;
    step();
    sh_ld_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (o8 !== exp_o(1'b1, 1'b0, 1'b0, 1'b0)) begin
        miscompares++;
        $display("FAIL man_hold%0d: got %b want %b", i, o8, exp_o(1, 0, 0, 0));
      end
      if (i < 3) step();
    end
    clk_inh = 1'b0; ser = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      vectors++;
      if (o8 !== exp_o(pat[7-i], 1'b0, 1'b0, 1'b0)) begin
        miscompares++;
        $display("FAIL man_shift%0d: got %b want %b", i, o8, exp_o(pat[7-i], 0, 0, 0));
      end
    end
    clk_inh = 1'b1; ser = 1'b0;
    step();
  endtask

  task automatic test_start_ignored();
    logic [7:0] pat_a = 8'hC3;
    logic [7:0] pat_b = 8'h5A;
    d8 = pat_a; start = 1'b1;
    step();
    start = 1'b0; d8 = pat_b;
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (o8 !== exp_o(pat_a[7-i], 1'b1, 1'b1, 1'b0)) begin
        miscompares++;
        $display("FAIL ign_bit%0d: got %b want %b", i, o8, exp_o(pat_a[7-i], 1, 1, 0));
      end
      start = (i == 3);
      step();
    end
    vectors++;
    if (o8 !== exp_o(pat_a[0], 1'b0, 1'b1, 1'b1)) begin
      miscompares++; $display("FAIL ign_done: got %b want %b", o8, exp_o(pat_a[0], 0, 1, 1));
    end
    start = 1'b1;
    step();
    vectors++;
    if (o8 !== exp_o(pat_a[0], 1'b0, 1'b0, 1'b0)) begin
      miscompares++;
      $display("FAIL ign_start_in_done: got %b want %b", o8, exp_o(pat_a[0], 0, 0, 0));
    end
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (o8 !== exp_o(pat_b[7-i], 1'b1, 1'b1, 1'b0)) begin
        miscompares++;
        $display("FAIL b2b_bit%0d: got %b want %b", i, o8, exp_o(pat_b[7-i], 1, 1, 0));
      end
      step();
    end
    vectors++;
    if (o8 !== exp_o(pat_b[0], 1'b0, 1'b1, 1'b1)) begin
      miscompares++; $display("FAIL b2b_done: got %b want %b", o8, exp_o(pat_b[0], 0, 1, 1));
    end
    step();
    vectors++;
    if (o8 !== exp_o(pat_b[0], 1'b0, 1'b0, 1'b0)) begin
      miscompares++; $display("FAIL b2b_idle: got %b want %b", o8, exp_o(pat_b[0], 0, 0, 0));
    end
    repeat (10) step();
  endtask

  task automatic test_reset_mid();
    logic [7:0] pat = 8'hA5;
    logic done_seen = 1'b0;
    logic busy_seen = 1'b0;
    d8 = pat; start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    vectors++;
    if (o8 !== exp_o(pat[3], 1'b1, 1'b1, 1'b0)) begin
      miscompares++; $display("FAIL rst_pre: got %b want %b", o8, exp_o(pat[3], 1, 1, 0));
    end
    rst_n = 1'b0;
    step();
    vectors++;
    if (o8 !== exp_o(1'b0, 1'b0, 1'b0, 1'b0)) begin
      miscompares++; $display("FAIL rst_mid: got %b want %b", o8, exp_o(0, 0, 0, 0));
    end
    rst_n = 1'b1;
    repeat (12) begin
      step();
      if (done8) done_seen = 1'b1;
      if (busy8) busy_seen = 1'b1;
    end
    vectors++;
    if ({done_seen, busy_seen} !== 2'b00) begin
      miscompares++;
      $display("FAIL rst_no_done: got done=%b busy=%b want 0 0", done_seen, busy_seen);
    end
  endtask

  task automatic test_start_vs_manual();
    logic [7:0] pat = 8'h96;
    clk_inh = 1'b1; sh_ld_n = 1'b0; d8 = pat; start = 1'b1;
    step();
    start = 1'b0; d8 = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (o8 !== exp_o(pat[7-i], 1'b1, 1'b1, 1'b0)) begin
        miscompares++;
        $display("FAIL prio_bit%0d: got %b want %b", i, o8, exp_o(pat[7-i], 1, 1, 0));
      end
      step();
    end
    vectors++;
    if (o8 !== exp_o(pat[0], 1'b0, 1'b1, 1'b1)) begin
      miscompares++; $display("FAIL prio_done: got %b want %b", o8, exp_o(pat[0], 0, 1, 1));
    end
    step();
    vectors++;
    if (o8 !== exp_o(pat[0], 1'b0, 1'b0, 1'b0)) begin
      miscompares++; $display("FAIL prio_idle: got %b want %b", o8, exp_o(pat[0], 0, 0, 0));
    end
    sh_ld_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_frame_a5();
    test_wide();
    test_manual();
    test_start_ignored();
    test_reset_mid();
    test_start_vs_manual();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
